// File: rtl/life_ctrl_if.sv
// Host-side command and pattern-load channel of the Game of Life generation controller.
// The host drives the master modport; life_ctrl sits on the slave modport.
interface life_ctrl_if #(
    parameter int COLS  = 8,
    parameter int DIV_W = 16,
    parameter int GEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DIV_W-1:0] period;
    logic [GEN_W-1:0] max_gen;
    logic             ld_valid;
    logic             ld_ready;
    logic [COLS-1:0]  ld_data;

    modport master (
        output cmd_valid, cmd_op, period, max_gen, ld_valid, ld_data,
        input  cmd_ready, ld_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, period, max_gen, ld_valid, ld_data,
        output cmd_ready, ld_ready
    );
endinterface

// File: rtl/life_ctrl.sv
// Game of Life generation controller: pattern load, single/free-running stepping, halt detection.
// Define LIFE_CTRL_STABLE_DETECT_EN to add the stable-pattern halt (halt_cause 11).
module life_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DIV_W = 16,
    parameter int GEN_W = 16
) (
    input  logic                     clk,
    input  logic                     _rst,
    life_ctrl_if.slave               host,
    input  logic [ROWS*COLS-1:0]     grid_state,
    output logic                     step_en,
    output logic                     load_en,
    output logic [$clog2(ROWS)-1:0]  load_row,
    output logic [COLS-1:0]          load_data,
    output logic [GEN_W-1:0]         gen_count,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               halt_cause
);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next, period_reg, period_next;
    logic [GEN_W-1:0] max_gen_reg, max_gen_next, gen_reg, gen_next;
    logic [ROW_W-1:0] row_reg, row_next, load_row_reg, load_row_next;
    logic [COLS-1:0]  load_data_reg, load_data_next;
    logic             step_reg, step_next, load_en_reg, load_en_next;
    logic             done_reg, done_next, check_reg, check_next;
    logic [1:0]       cause_reg, cause_next;

    logic             cmd_fire, ld_fire, discard, extinct, stable, check_halt, max_hit;
    logic [DIV_W-1:0] period_eff;
    logic [GEN_W-1:0] gen_inc;

    assign host.cmd_ready = (state_reg != LOAD);
    assign host.ld_ready  = (state_reg == LOAD);
    assign cmd_fire = host.cmd_valid && host.cmd_ready;
    assign ld_fire  = host.ld_valid && host.ld_ready;
    // An accepted STOP (or a LOAD that will actually start) cancels any pending halt check.
    assign discard  = cmd_fire && ((host.cmd_op == OP_STOP) ||
                                   (host.cmd_op == OP_LOAD && state_reg == IDLE));
    assign period_eff = (host.period == '0) ? DIV_W'(1) : host.period;
    assign extinct    = check_reg && (grid_state == '0);

`ifdef LIFE_CTRL_STABLE_DETECT_EN
    logic [ROWS*COLS-1:0] snap_reg;

    always_ff @(posedge clk) begin
        if (!_rst) begin
            snap_reg <= '0;
        end else if (step_en) begin
            snap_reg <= grid_state;
        end
    end

    assign stable = check_reg && !extinct && (grid_state == snap_reg);
`else
    assign stable = 1'b0;
`endif

    assign check_halt = (extinct || stable) && !discard && (state_reg != LOAD);
    // A halt seen in the check cycle also suppresses a step already queued by the divider.
    assign step_en = step_reg && !check_halt;
    assign gen_inc = gen_reg + GEN_W'(1);
    assign max_hit = step_en && (max_gen_reg != '0) && (gen_inc == max_gen_reg) &&
                     !discard && (state_reg != LOAD);

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            period_reg    <= '0;
            max_gen_reg   <= '0;
            gen_reg       <= '0;
            row_reg       <= '0;
            load_row_reg  <= '0;
            load_data_reg <= '0;
            step_reg      <= 1'b0;
            load_en_reg   <= 1'b0;
            done_reg      <= 1'b0;
            check_reg     <= 1'b0;
            cause_reg     <= 2'b00;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            period_reg    <= period_next;
            max_gen_reg   <= max_gen_next;
            gen_reg       <= gen_next;
            row_reg       <= row_next;
            load_row_reg  <= load_row_next;
            load_data_reg <= load_data_next;
            step_reg      <= step_next;
            load_en_reg   <= load_en_next;
            done_reg      <= done_next;
            check_reg     <= check_next;
            cause_reg     <= cause_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        period_next    = period_reg;
        max_gen_next   = max_gen_reg;
        gen_next       = gen_reg;
        row_next       = row_reg;
        load_row_next  = load_row_reg;
        load_data_next = load_data_reg;
        step_next      = 1'b0;
        load_en_next   = 1'b0;
        done_next      = 1'b0;
        cause_next     = cause_reg;
        check_next     = step_en;

        if (step_en) begin
            gen_next = gen_inc;
        end

        unique case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    unique case (host.cmd_op)
                        OP_LOAD: begin
                            state_next = LOAD;
                            row_next   = '0;
                            check_next = 1'b0;
                        end
                        OP_RUN: begin
                            state_next   = RUN;
                            period_next  = period_eff;
                            max_gen_next = host.max_gen;
                            // Divider is preloaded so the first step lands P cycles after accept.
                            if (period_eff == DIV_W'(1)) begin
                                step_next = 1'b1;
                                div_next  = period_eff;
                            end else begin
                                div_next = period_eff - DIV_W'(1);
                            end
                        end
                        OP_STEP: begin
                            step_next    = 1'b1;
                            max_gen_next = host.max_gen;
                        end
                        default: check_next = 1'b0;
                    endcase
                end
            end
            LOAD: begin
                if (ld_fire) begin
                    load_en_next   = 1'b1;
                    load_row_next  = row_reg;
                    load_data_next = host.ld_data;
                    row_next       = row_reg + ROW_W'(1);
                    if (row_reg == ROW_W'(ROWS - 1)) begin
                        state_next = IDLE;
                        gen_next   = '0;
                    end
                end
            end
            RUN: begin
                if (div_reg == DIV_W'(1)) begin
                    step_next = 1'b1;
                    div_next  = period_reg;
                end else begin
                    div_next = div_reg - DIV_W'(1);
                end
                if (cmd_fire && host.cmd_op == OP_STOP) begin
                    state_next = IDLE;
                    step_next  = 1'b0;
                    done_next  = 1'b1;
                    cause_next = 2'b00;
                    check_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // max_gen outranks the grid checks; reaching it drops this generation's check.
        if (max_hit) begin
            state_next = IDLE;
            step_next  = 1'b0;
            done_next  = 1'b1;
            cause_next = 2'b01;
            check_next = 1'b0;
        end else if (check_halt) begin
            state_next = IDLE;
            step_next  = 1'b0;
            done_next  = 1'b1;
            cause_next = extinct ? 2'b10 : 2'b11;
            check_next = 1'b0;
        end
    end

    assign load_en    = load_en_reg;
    assign load_row   = load_row_reg;
    assign load_data  = load_data_reg;
    assign gen_count  = gen_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign halt_cause = cause_reg;
endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: behavioural Game of Life grid, event scoreboard,
// table of command vectors plus hand-written STOP-on-expiry, stable-pattern and reset sequences.
module tb_life_ctrl;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DIV_W = 16;
    localparam int GEN_W = 16;
    localparam int N     = ROWS * COLS;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam int EV_STEP = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_DONE = 2;

    localparam int PAT_BLINK  = 0;
    localparam int PAT_SINGLE = 1;
    localparam int PAT_BLOCK  = 2;

    typedef struct {
        int kind;
        int edge_n;
        int a;
        int b;
    } ev_t;

    typedef struct {
        logic [1:0] op;
        int         per;
        int         mg;
        int         pat;
        int         nsteps;
        int         cause;
        bit         has_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] grid = '0;
    logic step_en, load_en, busy, done;
    logic [$clog2(ROWS)-1:0] load_row;
    logic [COLS-1:0] load_data;
    logic [GEN_W-1:0] gen_count;
    logic [1:0] halt_cause;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ev_t expq[$];
    vec_t vecs[8];

    life_ctrl_if #(.COLS(COLS), .DIV_W(DIV_W), .GEN_W(GEN_W)) hif ();

    life_ctrl #(.ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .GEN_W(GEN_W)) dut (
        .clk        (clk),
        ._rst       (rst_n),
        .host       (hif),
        .grid_state (grid),
        .step_en    (step_en),
        .load_en    (load_en),
        .load_row   (load_row),
        .load_data  (load_data),
        .gen_count  (gen_count),
        .busy       (busy),
        .done       (done),
        .halt_cause (halt_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
        logic [N-1:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                            c + dc >= 0 && c + dc < COLS) begin
                            n += int'(g[(r + dr) * COLS + c + dc]);
                        end
                    end
                end
                nx[r * COLS + c] = (n == 3) || (n == 2 && g[r * COLS + c]);
            end
        end
        return nx;
    endfunction

    // Behavioural cell grid driven only by the controller's enables.
    always @(posedge clk) begin
        if (load_en) grid[load_row * COLS +: COLS] <= load_data;
        else if (step_en) grid <= life_next(grid);
    end

    function automatic logic [COLS-1:0] pat_row(input int pat, input int r);
        logic [COLS-1:0] v;
        v = '0;
        if (pat == PAT_BLINK && r == 3) v = 8'h1C;
        if (pat == PAT_SINGLE && r == 4) v = 8'h08;
        if (pat == PAT_BLOCK && (r == 3 || r == 4)) v = 8'h18;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind, input int a, input int b);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d edge=%0d a=%0h b=%0h, required none",
                     kind, cyc, a, b);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.edge_n != cyc || e.a != a || e.b != b) begin
                errors++;
                $display("FAIL event: got kind=%0d edge=%0d a=%0h b=%0h, required kind=%0d edge=%0d a=%0h b=%0h",
                         kind, cyc, a, b, e.kind, e.edge_n, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (step_en) check_ev(EV_STEP, 0, 0);
        if (load_en) check_ev(EV_LOAD, int'(load_row), int'(load_data));
        if (done)    check_ev(EV_DONE, int'(halt_cause), int'(gen_count));
    end

    // Issues one command; expected step/done events are queued just before the accept edge.
    task automatic send(input logic [1:0] op, input int per, input int mg, input int nsteps,
                        input int cause, input bit has_done, input int egen);
        int n;
        int a;
        int p;
        int last;
        n = 0;
        @(negedge clk);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.period    = DIV_W'(per);
        hif.max_gen   = GEN_W'(mg);
        while (!hif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", longint'(hif.cmd_ready), 1);
        a = cyc + 1;
        p = (per == 0) ? 1 : per;
        last = a;
        for (int k = 0; k < nsteps; k++) begin
            last = (op == OP_STEP) ? a : a + p - 1 + k * p;
            expq.push_back(ev_t'{EV_STEP, last, 0, 0});
        end
        if (has_done) begin
            expq.push_back(ev_t'{EV_DONE, (cause == 0) ? a : ((cause == 1) ? last + 1 : last + 2),
                                 cause, egen});
        end
        @(posedge clk);
        #1;
        hif.cmd_valid = 1'b0;
    endtask

    task automatic load_pattern(input int pat);
        int n;
        logic [COLS-1:0] d;
        send(OP_LOAD, 0, 0, 0, 0, 1'b0, 0);
        for (int r = 0; r < ROWS; r++) begin
            n = 0;
            d = pat_row(pat, r);
            @(negedge clk);
            hif.ld_valid = 1'b1;
            hif.ld_data  = d;
            while (!hif.ld_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            expq.push_back(ev_t'{EV_LOAD, cyc + 1, r, int'(d)});
            @(posedge clk);
            #1;
            hif.ld_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk(name, longint'(expq.size()), 0);
        expq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_STEP, 0, 0, PAT_BLINK,  1, 0, 1'b0};
        vecs[1] = '{OP_RUN,  4, 3, PAT_BLINK,  3, 1, 1'b1};
        vecs[2] = '{OP_RUN,  1, 0, PAT_SINGLE, 1, 2, 1'b1};
        vecs[3] = '{OP_STEP, 0, 0, PAT_SINGLE, 1, 2, 1'b1};
        vecs[4] = '{OP_STEP, 0, 1, PAT_BLINK,  1, 1, 1'b1};
        vecs[5] = '{OP_RUN,  0, 2, PAT_BLINK,  2, 1, 1'b1};
        vecs[6] = '{OP_RUN,  3, 1, PAT_SINGLE, 1, 1, 1'b1};
        vecs[7] = '{OP_RUN,  2, 4, PAT_BLINK,  4, 1, 1'b1};

        hif.cmd_valid = 1'b0;
        hif.cmd_op    = OP_STOP;
        hif.period    = '0;
        hif.max_gen   = '0;
        hif.ld_valid  = 1'b0;
        hif.ld_data   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", longint'(hif.cmd_ready), 1);
        chk("reset_ld_ready",  longint'(hif.ld_ready), 0);
        chk("reset_enables",   longint'({step_en, load_en, done, busy}), 0);
        chk("reset_gen_cause", longint'({gen_count, halt_cause}), 0);
        chk("reset_load_bus",  longint'({load_row, load_data}), 0);
        rst_n = 1'b1;
        $display("reset: checked");

        for (int i = 0; i < 8; i++) begin
            load_pattern(vecs[i].pat);
            drain("load_drain");
            chk("load_gen_clear", longint'(gen_count), 0);
            chk("load_idle", longint'(busy), 0);
            send(vecs[i].op, vecs[i].per, vecs[i].mg, vecs[i].nsteps, vecs[i].cause,
                 vecs[i].has_done, vecs[i].nsteps);
            drain("vec_drain");
            chk("vec_gen", longint'(gen_count), longint'(vecs[i].nsteps));
            chk("vec_idle", longint'(busy), 0);
            if (vecs[i].has_done) chk("vec_cause", longint'(halt_cause), longint'(vecs[i].cause));
            $display("vec %0d: op=%0d period=%0d max_gen=%0d steps=%0d cause=%0d",
                     i, vecs[i].op, vecs[i].per, vecs[i].mg, vecs[i].nsteps, vecs[i].cause);
        end

        // STOP accepted on the very edge the divider expires.
        load_pattern(PAT_BLINK);
        drain("stop_load_drain");
        send(OP_RUN, 5, 0, 0, 0, 1'b0, 0);
        repeat (3) @(posedge clk);
        send(OP_STOP, 0, 0, 0, 0, 1'b1, 0);
        drain("stop_expiry_drain");
        chk("stop_expiry_cause", longint'(halt_cause), 0);
        chk("stop_expiry_gen", longint'(gen_count), 0);
        $display("seq stop_on_expiry: checked");

        // Still-life block under free-running P=1.
        load_pattern(PAT_BLOCK);
        drain("block_load_drain");
`ifdef LIFE_CTRL_STABLE_DETECT_EN
        send(OP_RUN, 1, 0, 1, 3, 1'b1, 1);
        drain("block_drain");
        chk("block_cause", longint'(halt_cause), 3);
        chk("block_gen", longint'(gen_count), 1);
`else
        send(OP_RUN, 1, 0, 5, 0, 1'b0, 0);
        repeat (4) @(posedge clk);
        send(OP_STOP, 0, 0, 0, 0, 1'b1, 5);
        drain("block_drain");
        chk("block_cause", longint'(halt_cause), 0);
        chk("block_gen", longint'(gen_count), 5);
`endif
        $display("seq stable_block: checked");

        // Reset asserted mid-RUN.
        load_pattern(PAT_BLINK);
        drain("rst_load_drain");
        send(OP_RUN, 2, 0, 2, 0, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrun_rst_enables", longint'({step_en, load_en, done, busy}), 0);
        chk("midrun_rst_gen", longint'(gen_count), 0);
        chk("midrun_rst_ready", longint'(hif.cmd_ready), 1);
        rst_n = 1'b1;
        drain("midrun_rst_drain");
        $display("seq reset_mid_run: checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
